mux_2to1: RTL and testbench



---
 rtl/mux_2to1_pkg.sv | 8 +
 rtl/mux_2to1_core.sv | 30 +++
 rtl/mux_2to1.sv | 68 ++++++
 tb/tb_mux_2to1.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mux_2to1_pkg.sv
// Shared definitions for the selector family (2:1 leaf and the trees built from it).
package mux_2to1_pkg;

  // Lane-select encodings used by every selector in the tree.
  localparam logic SEL_LANE0 = 1'b0;
  localparam logic SEL_LANE1 = 1'b1;

endpackage : mux_2to1_pkg

// File: rtl/mux_2to1_core.sv
// Purely combinational WIDTH-bit 2:1 lane selector.
// Lane 0 is the low slice of lanes_i, lane 1 the high slice.
// An unknown select propagates as an all-X result (no priority fallback).
module mux_2to1_core
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [2*WIDTH-1:0] lanes_i,
  input  logic               sel_i,
  output logic [WIDTH-1:0]   data_o
);

  logic [WIDTH-1:0] lane0_s;
  logic [WIDTH-1:0] lane1_s;

  assign lane0_s = lanes_i[WIDTH-1:0];
  assign lane1_s = lanes_i[2*WIDTH-1:WIDTH];

  // Pick the lane named by the select; anything else yields X so it is visible downstream.
  always_comb begin
    data_o = {WIDTH{1'b0}};
    case (sel_i)
      SEL_LANE0: data_o = lane0_s;
      SEL_LANE1: data_o = lane1_s;
      default:   data_o = {WIDTH{1'bx}};
    endcase
  end

endmodule : mux_2to1_core

// File: rtl/mux_2to1.sv
// Registered (or optionally combinational) 2:1 selector with a valid qualifier.
// REG_OUT=1: one-cycle latency, out holds on idle cycles, out_valid pulses once
//            per accepted input; synchronous active-low reset clears both.
// REG_OUT=0: out follows the selected lane directly, out_valid = in_valid & rst_n.
module mux_2to1
  import mux_2to1_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] in,
  input  logic               sel,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid
);

  logic [WIDTH-1:0] sel_data_s;

  mux_2to1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .lanes_i (in),
    .sel_i   (sel),
    .data_o  (sel_data_s)
  );

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             valid_q;
    logic             valid_d;

    // Next state: capture the selected lane only on valid cycles, otherwise hold.
    always_comb begin
      out_d   = out_q;
      valid_d = 1'b0;
      if (in_valid) begin
        out_d   = sel_data_s;
        valid_d = 1'b1;
      end else begin
        out_d   = out_q;
        valid_d = 1'b0;
      end
    end

    // Output register with synchronous reset; a valid input on a reset edge is dropped.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_q   <= {WIDTH{1'b0}};
        valid_q <= 1'b0;
      end else begin
        out_q   <= out_d;
        valid_q <= valid_d;
      end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Zero-latency path: reset only masks the valid flag.
    assign out       = sel_data_s;
    assign out_valid = in_valid & rst_n;
  end

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Self-checking bench: three instances (W1 registered, W8 registered, W4 combinational)
// share clock and reset; a lane-arithmetic reference model predicts every output.
module tb_mux_2to1;

  logic       clk;
  logic       rst_n;

  logic [1:0] in1;
  logic       sel1, vld1;
  logic [0:0] out1;
  logic       ov1;

  logic [15:0] in8;
  logic        sel8, vld8;
  logic [7:0]  out8;
  logic        ov8;

  logic [7:0] in4;
  logic       sel4, vld4;
  logic [3:0] out4;
  logic       ov4;

  int errors = 0;
  int checks = 0;

  // Reference model state for the registered instances.
  int e1, e8;
  int v1, v8;

  mux_2to1 #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1), .in_valid(vld1),
    .out(out1), .out_valid(ov1)
  );

  mux_2to1 #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .in_valid(vld8),
    .out(out8), .out_valid(ov8)
  );

  mux_2to1 #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel4), .in_valid(vld4),
    .out(out4), .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input int exp_v);
    logic [7:0] expv;
    expv = exp_v[7:0];
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check the combinational instance, predict, clock, check registered ones.
  task automatic cycle(input string tag);
    int c_out;
    int c_v;
    #1;
    c_out = sel4 ? (int'(in4) / 16) : (int'(in4) % 16);
    c_v   = (vld4 && rst_n) ? 1 : 0;
    chk({tag, ".w4.out"}, {4'h0, out4}, c_out);
    chk({tag, ".w4.valid"}, {7'h0, ov4}, c_v);
    if (!rst_n) begin
      e1 = 0; v1 = 0; e8 = 0; v8 = 0;
    end else begin
      if (vld1) e1 = sel1 ? (int'(in1) / 2) : (int'(in1) % 2);
      v1 = vld1 ? 1 : 0;
      if (vld8) e8 = sel8 ? (int'(in8) / 256) : (int'(in8) % 256);
      v8 = vld8 ? 1 : 0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".w1.out"}, {7'h0, out1}, e1);
    chk({tag, ".w1.valid"}, {7'h0, ov1}, v1);
    chk({tag, ".w8.out"}, out8, e8);
    chk({tag, ".w8.valid"}, {7'h0, ov8}, v8);
  endtask

  initial begin
    int sweep_exp [8];
    sweep_exp = '{0, 0, 1, 0, 0, 1, 1, 1};

    rst_n = 1'b0;
    in1 = 2'b11; sel1 = 1'b1; vld1 = 1'b1;
    in8 = 16'h0000; sel8 = 1'b0; vld8 = 1'b1;
    in4 = 8'h96; sel4 = 1'b0; vld4 = 1'b1;
    e1 = 0; e8 = 0; v1 = 0; v8 = 0;

    // Reset held two cycles with valid data present.
    cycle("rst0");
    chk("rst0.w1.out_zero", {7'h0, out1}, 0);
    cycle("rst1");
    rst_n = 1'b1;
    cycle("rst_release");
    chk("rst_release.w1.out_one", {7'h0, out1}, 1);

    // Exhaustive 1-bit sweep of {lane1, lane0, sel}.
    for (int v = 0; v < 8; v++) begin
      in1  = 2'(v / 2);
      sel1 = 1'(v % 2);
      vld1 = 1'b1;
      cycle("sweep");
      chk("sweep.table", {7'h0, out1}, sweep_exp[v]);
    end

    // Valid gating on the 8-bit instance.
    in8 = 16'hA53C; sel8 = 1'b0; vld8 = 1'b1;
    cycle("gate_on");
    chk("gate_on.const", out8, 8'h3C);
    vld8 = 1'b0; sel8 = 1'b1;
    cycle("gate_off");
    chk("gate_off.hold", out8, 8'h3C);

    // Wide lanes with sel toggling every cycle.
    in8 = 16'hFF00; vld8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel8 = 1'(i % 2);
      cycle("toggle");
      chk("toggle.const", out8, (i % 2 == 1) ? 8'hFF : 8'h00);
    end

    // Combinational instance: same-cycle selection and valid masking.
    in4 = 8'h96; sel4 = 1'b0; vld4 = 1'b1;
    cycle("comb_sel0");
    sel4 = 1'b1;
    #1;
    chk("comb_sel1.const", {4'h0, out4}, 9);
    vld4 = 1'b0;
    cycle("comb_novalid");

    // Mid-stream reset with continuous valid.
    vld1 = 1'b1; vld8 = 1'b1; vld4 = 1'b1;
    in8 = 16'h1234; sel8 = 1'b1;
    cycle("mid_pre");
    rst_n = 1'b0;
    cycle("mid_rst");
    chk("mid_rst.valid_low", {7'h0, ov8}, 0);
    rst_n = 1'b1;
    cycle("mid_resume");
    chk("mid_resume.valid_high", {7'h0, ov8}, 1);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 60; i++) begin
      rst_n = ($urandom_range(0, 15) != 0);
      in1   = 2'($urandom);
      sel1  = 1'($urandom);
      vld1  = 1'($urandom);
      in8   = 16'($urandom);
      sel8  = 1'($urandom);
      vld8  = ($urandom_range(0, 3) != 0);
      in4   = 8'($urandom);
      sel4  = 1'($urandom);
      vld4  = 1'($urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_2to1
